// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master
// indices and the per-master request bundle.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TMO  = 2'd2
   } arb_state_e;

   localparam logic M_IF   = 1'b0;
   localparam logic M_DATA = 1'b1;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;

   typedef struct packed {
      logic               cyc;
      logic               stb;
      logic               we;
      logic [WB_AW-1:0]   adr;
      logic [WB_DW-1:0]   dat;
      logic [WB_DW/8-1:0] sel;
   } wb_req_t;

   function automatic logic [1:0] onehot2(input logic idx);
      logic [1:0] vec;
      vec = 2'b00;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-input round-robin picker; remembers who was granted last so that
// a tie goes to the other master.
module wb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic       pick
);
   import wb_arb_pkg::*;

   logic last_grant_r;

   // A lone requester wins; on a tie the master not served last wins
   always_comb begin
      pick = M_IF;
      case (req)
         2'b01:   pick = M_IF;
         2'b10:   pick = M_DATA;
         2'b11:   pick = ~last_grant_r;
         default: pick = M_IF;
      endcase
   end

   // Reset to M_DATA so that the instruction port wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= M_DATA;
      end else if (grant_en) begin
         last_grant_r <= pick;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter with per-CYC bus lock, registered
// owner and a watchdog that ends stalled slave accesses with ERR.
module wb_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            CLK_I,
   input  logic            RES_I,
   input  logic            M0_CYC_I,
   input  logic            M0_STB_I,
   input  logic            M0_WE_I,
   input  logic [AW-1:0]   M0_ADR_I,
   input  logic [DW-1:0]   M0_DAT_I,
   input  logic [DW/8-1:0] M0_SEL_I,
   output logic [DW-1:0]   M0_DAT_O,
   output logic            M0_ACK_O,
   output logic            M0_ERR_O,
   input  logic            M1_CYC_I,
   input  logic            M1_STB_I,
   input  logic            M1_WE_I,
   input  logic [AW-1:0]   M1_ADR_I,
   input  logic [DW-1:0]   M1_DAT_I,
   input  logic [DW/8-1:0] M1_SEL_I,
   output logic [DW-1:0]   M1_DAT_O,
   output logic            M1_ACK_O,
   output logic            M1_ERR_O,
   output logic            S_CYC_O,
   output logic            S_STB_O,
   output logic            S_WE_O,
   output logic [AW-1:0]   S_ADR_O,
   output logic [DW-1:0]   S_DAT_O,
   output logic [DW/8-1:0] S_SEL_O,
   input  logic [DW-1:0]   S_DAT_I,
   input  logic            S_ACK_I,
   input  logic            S_ERR_I,
   output logic [1:0]      GNT_O,
   output logic            TMO_O
);
   import wb_arb_pkg::*;

   localparam int SW = DW / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_e    state_r;
   logic          owner_r;
   logic [1:0]    gnt_r;
   logic          tmo_r;
   logic [CW-1:0] cnt_r;

   wb_req_t       m0_req_s;
   wb_req_t       m1_req_s;
   wb_req_t       bus_req_s;
   logic          pick_s;
   logic          grant_en_s;
   logic          busy_s;
   logic          own_cyc_s;
   logic          stall_s;
   logic          fire_s;
   logic [1:0]    ack_s;
   logic [1:0]    err_s;

   assign m0_req_s = '{cyc: M0_CYC_I, stb: M0_STB_I, we: M0_WE_I,
                       adr: WB_AW'(M0_ADR_I), dat: WB_DW'(M0_DAT_I), sel: (WB_DW/8)'(M0_SEL_I)};
   assign m1_req_s = '{cyc: M1_CYC_I, stb: M1_STB_I, we: M1_WE_I,
                       adr: WB_AW'(M1_ADR_I), dat: WB_DW'(M1_DAT_I), sel: (WB_DW/8)'(M1_SEL_I)};

   assign busy_s     = (state_r == BUSY);
   assign grant_en_s = (state_r == IDLE) && (M0_CYC_I || M1_CYC_I);
   assign own_cyc_s  = (owner_r == M_DATA) ? M1_CYC_I : M0_CYC_I;

   wb_rr_arb2 u_rr (
      .clk      (CLK_I),
      .rst      (RES_I),
      .req      ({M1_CYC_I, M0_CYC_I}),
      .grant_en (grant_en_s),
      .pick     (pick_s)
   );

   // Slave side sees the owner only while BUSY; IDLE and TMO park the bus at zero
   always_comb begin
      bus_req_s = '0;
      if (!busy_s) begin
         bus_req_s = '0;
      end else if (owner_r == M_DATA) begin
         bus_req_s = m1_req_s;
      end else begin
         bus_req_s = m0_req_s;
      end
   end

   assign S_CYC_O = bus_req_s.cyc;
   assign S_STB_O = bus_req_s.stb;
   assign S_WE_O  = bus_req_s.we;
   assign S_ADR_O = AW'(bus_req_s.adr);
   assign S_DAT_O = DW'(bus_req_s.dat);
   assign S_SEL_O = SW'(bus_req_s.sel);

   // Termination routing; ACK and ERR pass untouched, even if both are set
   always_comb begin
      ack_s = 2'b00;
      err_s = 2'b00;
      if (RES_I) begin
         ack_s = 2'b00;
         err_s = 2'b00;
      end else if (busy_s) begin
         ack_s[owner_r] = S_ACK_I;
         err_s[owner_r] = S_ERR_I;
      end else if (state_r == TMO) begin
         err_s[owner_r] = 1'b1;
      end else begin
         ack_s = 2'b00;
         err_s = 2'b00;
      end
   end

   assign M0_ACK_O = ack_s[0];
   assign M0_ERR_O = err_s[0];
   assign M1_ACK_O = ack_s[1];
   assign M1_ERR_O = err_s[1];

   // Read data reaches the owner only; the other master sees zero
   always_comb begin
      M0_DAT_O = '0;
      M1_DAT_O = '0;
      if (busy_s && owner_r == M_DATA) begin
         M1_DAT_O = S_DAT_I;
      end else if (busy_s) begin
         M0_DAT_O = S_DAT_I;
      end else begin
         M0_DAT_O = '0;
         M1_DAT_O = '0;
      end
   end

   // A termination in the limit cycle wins over the watchdog
   assign stall_s = busy_s && bus_req_s.stb && !S_ACK_I && !S_ERR_I;
   assign fire_s  = (TIMEOUT > 0) && stall_s && (cnt_r == CNT_LIM);

   // Arbitration FSM with watchdog counter and registered grant/timeout flags
   always_ff @(posedge CLK_I) begin
      if (RES_I) begin
         state_r <= IDLE;
         owner_r <= M_IF;
         gnt_r   <= 2'b00;
         tmo_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               tmo_r <= 1'b0;
               cnt_r <= '0;
               if (grant_en_s) begin
                  state_r <= BUSY;
                  owner_r <= pick_s;
                  gnt_r   <= onehot2(pick_s);
               end else begin
                  state_r <= IDLE;
                  gnt_r   <= 2'b00;
               end
            end
            BUSY: begin
               if (!own_cyc_s) begin
                  state_r <= IDLE;
                  gnt_r   <= 2'b00;
                  tmo_r   <= 1'b0;
                  cnt_r   <= '0;
               end else if (fire_s) begin
                  state_r <= TMO;
                  tmo_r   <= 1'b1;
                  cnt_r   <= '0;
               end else begin
                  tmo_r <= 1'b0;
                  cnt_r <= stall_s ? cnt_r + 1'b1 : '0;
               end
            end
            TMO: begin
               tmo_r <= 1'b0;
               cnt_r <= '0;
               if (own_cyc_s) begin
                  state_r <= BUSY;
               end else begin
                  state_r <= IDLE;
                  gnt_r   <= 2'b00;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt_r   <= 2'b00;
               tmo_r   <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign GNT_O = gnt_r;
   assign TMO_O = tmo_r;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: stimulus queues expected terminations,
// a negedge monitor pops and compares them whenever a master sees ACK/ERR.
module tb_wb_bus_arbiter;

   logic        clk = 1'b0;
   logic        RES_I = 1'b1;
   logic        M0_CYC_I = 1'b0, M0_STB_I = 1'b0, M0_WE_I = 1'b0;
   logic [31:0] M0_ADR_I = 32'h0, M0_DAT_I = 32'h0;
   logic [3:0]  M0_SEL_I = 4'h0;
   logic [31:0] M0_DAT_O;
   logic        M0_ACK_O, M0_ERR_O;
   logic        M1_CYC_I = 1'b0, M1_STB_I = 1'b0, M1_WE_I = 1'b0;
   logic [31:0] M1_ADR_I = 32'h0, M1_DAT_I = 32'h0;
   logic [3:0]  M1_SEL_I = 4'h0;
   logic [31:0] M1_DAT_O;
   logic        M1_ACK_O, M1_ERR_O;
   logic        S_CYC_O, S_STB_O, S_WE_O;
   logic [31:0] S_ADR_O, S_DAT_O;
   logic [3:0]  S_SEL_O;
   logic [31:0] S_DAT_I = 32'h0;
   logic        S_ACK_I = 1'b0, S_ERR_I = 1'b0;
   logic [1:0]  GNT_O;
   logic        TMO_O;

   wb_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .CLK_I(clk), .RES_I(RES_I),
      .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
      .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_SEL_I(M0_SEL_I),
      .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
      .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
      .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_SEL_I(M1_SEL_I),
      .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
      .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O),
      .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O),
      .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .S_ERR_I(S_ERR_I),
      .GNT_O(GNT_O), .TMO_O(TMO_O)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  term;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        tmo;
      logic        scyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [3:0] term, input logic [31:0] d0, input logic [31:0] d1,
                       input logic tmo, input logic scyc);
      exp_t e;
      e.term = term; e.d0 = d0; e.d1 = d1; e.tmo = tmo; e.scyc = scyc;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RES_I = 1'b1;
      tick();
      tick();
      RES_I = 1'b0;
   endtask

   // Monitor: any termination towards a master must match the queue head
   always @(negedge clk) begin
      if (M0_ACK_O || M0_ERR_O || M1_ACK_O || M1_ERR_O) begin
         if (exp_q.size() == 0) begin
            check("unexpected_term", {M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O}, 4'b0000);
         end else begin
            mon_e = exp_q.pop_front();
            check("mon_term", {M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O}, mon_e.term);
            check("mon_m0_dat", M0_DAT_O, mon_e.d0);
            check("mon_m1_dat", M1_DAT_O, mon_e.d1);
            check("mon_tmo", TMO_O, mon_e.tmo);
            check("mon_scyc", S_CYC_O, mon_e.scyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      do_reset();
      check("rst_gnt", GNT_O, 2'b00);
      check("rst_scyc", S_CYC_O, 1'b0);
      check("rst_tmo", TMO_O, 1'b0);

      // Single M0 read, slave answers after one wait cycle
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_WE_I = 1'b0; M0_ADR_I = 32'h0000_0100; M0_SEL_I = 4'hF;
      #1;
      check("t1_latency", S_CYC_O, 1'b0);
      tick();
      check("t1_scyc", S_CYC_O, 1'b1);
      check("t1_gnt", GNT_O, 2'b01);
      check("t1_adr", S_ADR_O, 32'h0000_0100);
      tick();
      S_ACK_I = 1'b1; S_DAT_I = 32'hDEAD_BEEF;
      push(4'b1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      tick();
      S_ACK_I = 1'b0; S_DAT_I = 32'h0; M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      tick();
      check("t1_idle_gnt", GNT_O, 2'b00);

      // Simultaneous requests after reset: M0, gap, M1, then M0 again
      do_reset();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h400;
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_WE_I = 1'b0; M1_ADR_I = 32'h500; M1_SEL_I = 4'hF;
      tick();
      check("t2_gnt_first", GNT_O, 2'b01);
      check("t2_adr_first", S_ADR_O, 32'h400);
      S_ACK_I = 1'b1; S_DAT_I = 32'h1111_1111;
      push(4'b1000, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
      tick();
      S_ACK_I = 1'b0; S_DAT_I = 32'h0; M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      tick();
      check("t2_gap_gnt", GNT_O, 2'b00);
      check("t2_gap_scyc", S_CYC_O, 1'b0);
      tick();
      check("t2_gnt_second", GNT_O, 2'b10);
      check("t2_adr_second", S_ADR_O, 32'h500);
      S_ACK_I = 1'b1; S_DAT_I = 32'h2222_2222;
      push(4'b0010, 32'h0, 32'h2222_2222, 1'b0, 1'b1);
      tick();
      S_ACK_I = 1'b0; S_DAT_I = 32'h0; M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
      tick();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
      tick();
      check("t2_gnt_alternate", GNT_O, 2'b01);
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0; M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
      tick();

      // M1 four-beat write burst keeps the bus while M0 waits
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_WE_I = 1'b1; M1_SEL_I = 4'hF; M1_ADR_I = 32'h200;
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_WE_I = 1'b0; M0_ADR_I = 32'h600;
      tick();
      check("t3_gnt", GNT_O, 2'b10);
      for (int i = 0; i < 4; i++) begin
         M1_ADR_I = 32'h200 + 32'(4 * i);
         M1_DAT_I = 32'hA000_0000 + 32'(i);
         S_ACK_I = 1'b1;
         #1;
         check("t3_adr", S_ADR_O, 32'h200 + 32'(4 * i));
         check("t3_wdat", S_DAT_O, 32'hA000_0000 + 32'(i));
         check("t3_lock_gnt", GNT_O, 2'b10);
         push(4'b0010, 32'h0, 32'h0, 1'b0, 1'b1);
         tick();
      end
      S_ACK_I = 1'b0; M1_CYC_I = 1'b0; M1_STB_I = 1'b0; M1_WE_I = 1'b0;
      tick();
      check("t3_gap_gnt", GNT_O, 2'b00);
      tick();
      check("t3_m0_gnt", GNT_O, 2'b01);
      check("t3_m0_adr", S_ADR_O, 32'h600);
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      tick();

      // Watchdog fires after 16 unanswered strobed cycles
      do_reset();
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h700;
      tick();
      repeat (15) tick();
      check("t4_pre_tmo", TMO_O, 1'b0);
      check("t4_pre_scyc", S_CYC_O, 1'b1);
      push(4'b0100, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("t4_tmo", TMO_O, 1'b1);
      check("t4_tmo_stb", S_STB_O, 1'b0);
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      tick();
      check("t4_tmo_pulse", TMO_O, 1'b0);
      check("t4_idle_gnt", GNT_O, 2'b00);

      // ACK in the limit cycle beats the watchdog
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h800;
      tick();
      repeat (15) tick();
      S_ACK_I = 1'b1; S_DAT_I = 32'hCAFE_0005;
      push(4'b1000, 32'hCAFE_0005, 32'h0, 1'b0, 1'b1);
      tick();
      S_ACK_I = 1'b0; S_DAT_I = 32'h0;
      check("t5_no_tmo", TMO_O, 1'b0);
      check("t5_still_busy", S_CYC_O, 1'b1);
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
      tick();

      // Reset pulse in the middle of an M1 transfer
      M1_CYC_I = 1'b1; M1_STB_I = 1'b1; M1_WE_I = 1'b0; M1_ADR_I = 32'h900;
      tick();
      check("t6_gnt", GNT_O, 2'b10);
      RES_I = 1'b1;
      tick();
      RES_I = 1'b0;
      M0_CYC_I = 1'b1; M0_STB_I = 1'b1;
      check("t6_scyc", S_CYC_O, 1'b0);
      check("t6_sstb", S_STB_O, 1'b0);
      check("t6_gnt_rst", GNT_O, 2'b00);
      check("t6_m1_term", {M1_ACK_O, M1_ERR_O}, 2'b00);
      tick();
      check("t6_gnt_m0", GNT_O, 2'b01);
      M0_CYC_I = 1'b0; M0_STB_I = 1'b0; M1_CYC_I = 1'b0; M1_STB_I = 1'b0;
      tick();
      tick();

      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
